// File: rtl/arbiter_pkg.sv
// arbiter_pkg: state encoding and default tie-break mode for the two-requester arbiter.
package arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;
    localparam bit RR_EN_DEFAULT = 1'b0;
endpackage

// File: rtl/arbiter.sv
// arbiter: registered, mutually exclusive, non-preemptive grant of one resource to req_0 or req_1.
module arbiter
    import arbiter_pkg::*;
#(
    parameter bit RR_EN = RR_EN_DEFAULT
) (
    input  logic clk,
    input  logic nreset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);
    state_e state_q, state_d;
    logic   last_q, last_d;
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (req_0 && (!req_1 || !RR_EN || last_q)) ? GNT0 : req_1 ? GNT1 : IDLE;
            GNT0:    state_d = req_0 ? GNT0 : req_1 ? GNT1 : IDLE;
            GNT1:    state_d = req_1 ? GNT1 : req_0 ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        last_d = (state_d == GNT0) ? 1'b0 : (state_d == GNT1) ? 1'b1 : last_q;
    end
    // History resets to "last served = 1" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end
    assign gnt_0 = (state_q == GNT0);
    assign gnt_1 = (state_q == GNT1);
endmodule

// File: tb/tb_arbiter.sv
// tb_arbiter: directed and random stimulus on fixed-priority and round-robin arbiters against an owner/history model.
module tb_arbiter;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic req_0 = 1'b0;
    logic req_1 = 1'b0;
    logic f_g0, f_g1, r_g0, r_g1;
    int   checks = 0;
    int   failures = 0;
    int   holder [2];
    int   last [2];

    always #5 clk = ~clk;

    arbiter #(.RR_EN(1'b0)) u_fix (.clk(clk), .nreset(nreset), .req_0(req_0), .req_1(req_1), .gnt_0(f_g0), .gnt_1(f_g1));
    arbiter #(.RR_EN(1'b1)) u_rr  (.clk(clk), .nreset(nreset), .req_0(req_0), .req_1(req_1), .gnt_0(r_g0), .gnt_1(r_g1));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Owner keeps the resource while requesting; otherwise a lone requester
    // takes it, and a tie goes to 0 unless round-robin saw 0 served last.
    function automatic int pick(int h, int l, int rr, logic a, logic b);
        if (h == 0 && a) return 0;
        if (h == 1 && b) return 1;
        if (a && b) return (rr == 0 || l == 1) ? 0 : 1;
        return a ? 0 : b ? 1 : -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            holder[k] = -1;
            last[k] = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_fix_g0"}, f_g0, holder[0] == 0);
        chk({tag, "_fix_g1"}, f_g1, holder[0] == 1);
        chk({tag, "_rr_g0"}, r_g0, holder[1] == 0);
        chk({tag, "_rr_g1"}, r_g1, holder[1] == 1);
        chk({tag, "_mutex"}, (f_g0 & f_g1) | (r_g0 & r_g1), 1'b0);
    endtask

    task automatic step(input logic a, input logic b, input string tag);
        @(negedge clk);
        req_0 = a;
        req_1 = b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            holder[k] = pick(holder[k], last[k], k, a, b);
            if (holder[k] >= 0) last[k] = holder[k];
        end
        #1;
        check_all(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        req_0 = 1'b0;
        req_1 = 1'b0;
        nreset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("por");
        repeat (2) @(negedge clk);
        release_reset();
        @(posedge clk);
        #1;
        check_all("post_rel");

        step(1, 0, "hold0_a");
        step(1, 0, "hold0_b");
        #1;
        nreset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_0 = 1'b1;
            req_1 = 1'b1;
            @(posedge clk);
            #1;
            check_all("in_rst");
        end
        for (int pass = 0; pass < 2; pass++) begin
            release_reset();
            step(1, 0, "single0");
            step(0, 0, "single0_drop");
            step(0, 1, "single1");
            step(0, 0, "single1_drop");
            step(1, 1, "tie");
            step(0, 1, "handoff");
            step(1, 1, "nopreempt_a");
            step(1, 1, "nopreempt_b");
            step(1, 0, "nopreempt_rel");
            step(0, 0, "release");
            step(1, 1, "rr_tie1");
            step(0, 0, "rr_gap");
            step(1, 1, "rr_tie2");
            step(0, 0, "rr_end");
            @(negedge clk);
            #2;
            nreset = 1'b0;
            #1;
            model_reset();
            check_all("rst_pass");
        end
        release_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                nreset = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                release_reset();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
